// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: two-entry skid buffer with valid/ready handshake,
// registered in_ready/out_valid/out_data and a synchronous flush that inserts a bubble.
module pipe_stage_buf #(
   parameter int               WIDTH  = 82,
   parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] main_data_r;
   logic [WIDTH-1:0] main_data_nxt_s;
   logic [WIDTH-1:0] skid_data_r;
   logic [WIDTH-1:0] skid_data_nxt_s;
   logic             main_valid_r;
   logic             skid_valid_r;
   logic             in_ready_r;
   logic             push_s;
   logic             pop_s;

   assign push_s = in_valid & in_ready_r;
   assign pop_s  = main_valid_r & out_ready;

   // Next-state and next-payload selection; flush overrides every transfer.
   always_comb begin
      state_nxt_s     = state_r;
      main_data_nxt_s = main_data_r;
      skid_data_nxt_s = skid_data_r;
      if (flush) begin
         state_nxt_s     = ST_EMPTY;
         main_data_nxt_s = BUBBLE;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (push_s) begin
                  main_data_nxt_s = in_data;
                  state_nxt_s     = ST_ONE;
               end else begin
                  state_nxt_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (push_s && pop_s) begin
                  main_data_nxt_s = in_data;
                  state_nxt_s     = ST_ONE;
               end else if (push_s) begin
                  skid_data_nxt_s = in_data;
                  state_nxt_s     = ST_FULL;
               end else if (pop_s) begin
                  // main_data keeps the consumed value while invalid
                  state_nxt_s = ST_EMPTY;
               end else begin
                  state_nxt_s = ST_ONE;
               end
            end
            ST_FULL: begin
               if (pop_s) begin
                  main_data_nxt_s = skid_data_r;
                  state_nxt_s     = ST_ONE;
               end else begin
                  state_nxt_s = ST_FULL;
               end
            end
            default: begin
               state_nxt_s     = ST_EMPTY;
               main_data_nxt_s = BUBBLE;
            end
         endcase
      end
   end

   // State, payload and handshake registers; flags derive from next state so they stay registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_EMPTY;
         main_data_r  <= BUBBLE;
         skid_data_r  <= BUBBLE;
         main_valid_r <= 1'b0;
         skid_valid_r <= 1'b0;
         in_ready_r   <= 1'b1;
      end else begin
         state_r      <= state_nxt_s;
         main_data_r  <= main_data_nxt_s;
         skid_data_r  <= skid_data_nxt_s;
         main_valid_r <= (state_nxt_s != ST_EMPTY);
         skid_valid_r <= (state_nxt_s == ST_FULL);
         in_ready_r   <= (state_nxt_s != ST_FULL);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = main_valid_r;
   assign out_data  = main_data_r;
   assign occupancy = {1'b0, main_valid_r} + {1'b0, skid_valid_r};

endmodule
